uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 21 ++
 rtl/uart_rx.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
// UART_RX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  function automatic int calc_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, hit when the count reaches target
module uart_baud_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] target,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

  assign hit = (cnt == target);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_edge,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CPB  = calc_cpb(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [CW-1:0] target;
  logic          hit;
  logic          clr;

  // The counter is held at zero in IDLE and restarts on every sample point.
  assign clr    = (state == ST_IDLE) || hit;
  assign target = (state == ST_START) ? CW'(HALF - 1) : CW'(CPB - 1);

  uart_baud_cnt #(.W(CW)) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .target (target),
    .hit    (hit)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_edge && !rx) state <= ST_START;
        end
        ST_START: begin
          if (hit) begin
            bit_idx <= '0;
            state   <= rx ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (hit) begin
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (hit) begin
            par_bad <= rx ^ (^shreg);
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (hit) begin
            data      <= shreg;
            frame_err <= !rx;
`ifdef UART_RX_PARITY_EN
            valid      <= rx && !par_bad;
            parity_err <= par_bad;
`else
            valid      <= rx;
`endif
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
